piso_serializer: RTL and testbench

- Parallel-in, serial-out converter; the send-side counterpart to the parallel capture registers in the components library.
- Accepts an N-bit word on a valid/ready input handshake.
- Emits the word one bit per accepted cycle on a valid/ready output handshake, with a last-bit flag.
- Used ahead of bit-serial links (SPI-style shifters, LED/serial drivers) in the lab designs.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_serializer_reg.sv | 28 ++
 rtl/piso_serializer.sv | 127 ++++++++++++
 tb/tb_piso_serializer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types for the parallel-in, serial-out serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } piso_state_t;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_serializer_reg.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_reg
// Description : Generic register with synchronous reset and load enable;
//               reset takes priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             ena,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= RST_VAL;
        end else if (ena) begin
            o_q <= i_d;
        end
    end

endmodule : piso_serializer_reg
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Accepts an N-bit word on a valid/ready handshake and emits it
//               one bit per accepted cycle, flagging the final bit.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   N          = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         ena,
    input  wire logic [N-1:0] i_data,
    input  wire logic         i_valid,
    output logic              i_ready,
    output logic              o_bit,
    output logic              o_valid,
    input  wire logic         o_ready,
    output logic              o_last,
    output logic              busy
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    piso_state_t   r_state;
    logic [0:0]    w_state_q;
    logic [0:0]    w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic [N-1:0]  r_sr;
    logic [N-1:0]  w_sr_d;
    logic [N-1:0]  w_sr_shifted;
    logic          w_accept;
    logic          w_xfer;
    logic          w_head;

    piso_serializer_reg #(
        .WIDTH   (1),
        .RST_VAL (1'(S_IDLE))
    ) u_state_reg (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .i_d (w_state_d),
        .o_q (w_state_q)
    );

    piso_serializer_reg #(
        .WIDTH   (CW),
        .RST_VAL ('0)
    ) u_cnt_reg (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .i_d (w_cnt_d),
        .o_q (r_cnt)
    );

    assign r_state = piso_state_t'(w_state_q);

    // Shift toward whichever end drives o_bit, filling the vacated end with 0.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_shifted = {r_sr[N-2:0], 1'b0};
            assign w_head       = r_sr[N-1];
        end else begin : g_lsb_first
            assign w_sr_shifted = {1'b0, r_sr[N-1:1]};
            assign w_head       = r_sr[0];
        end
    endgenerate

    assign w_accept = ena & i_valid & (r_state == S_IDLE);
    assign w_xfer   = ena & o_ready & (r_state == S_SHIFT);

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = r_cnt;
        w_sr_d    = r_sr;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_d = 1'(S_SHIFT);
                    w_cnt_d   = CNT_LAST;
                    w_sr_d    = i_data;
                end
            end
            S_SHIFT: begin
                if (w_xfer) begin
                    if (r_cnt != '0) begin
                        w_cnt_d = r_cnt - CW'(1);
                        w_sr_d  = w_sr_shifted;
                    end else begin
                        w_state_d = 1'(S_IDLE);
                        w_sr_d    = '0;
                    end
                end
            end
            default: begin
                w_state_d = 1'(S_IDLE);
            end
        endcase
    end

    // The shift register lives inline; it follows the same rst/ena priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (ena) begin
            r_sr <= w_sr_d;
        end
    end

    // o_valid deliberately ignores ena so the bit is held visible while stalled.
    assign o_valid = (r_state == S_SHIFT);
    assign busy    = (r_state == S_SHIFT);
    assign i_ready = ena & (r_state == S_IDLE);
    assign o_bit   = o_valid ? w_head : IDLE_LEVEL;
    assign o_last  = o_valid & (r_cnt == '0);

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench; MSB-first and LSB-first instances share
//               stimulus and are compared against a word/bit-index model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic [N-1:0] i_data = '0;
    logic         i_valid = 1'b0;
    logic         o_ready = 1'b0;

    logic m_i_ready, m_o_bit, m_o_valid, m_o_last, m_busy_o;
    logic l_i_ready, l_o_bit, l_o_valid, l_o_last, l_busy_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: whether a word is in flight, the word, bits already sent.
    bit           mdl_busy = 1'b0;
    logic [N-1:0] mdl_word = '0;
    int           mdl_idx  = 0;

    // Words reassembled from the serial streams.
    logic [N-1:0] rx_m = '0, rx_l = '0;
    logic [N-1:0] last_m = '0, last_l = '0;

    always #5 clk = ~clk;

    piso_serializer #(.N(N), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_m (
        .clk(clk), .rst(rst), .ena(ena), .i_data(i_data), .i_valid(i_valid),
        .i_ready(m_i_ready), .o_bit(m_o_bit), .o_valid(m_o_valid),
        .o_ready(o_ready), .o_last(m_o_last), .busy(m_busy_o)
    );

    piso_serializer #(.N(N), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_l (
        .clk(clk), .rst(rst), .ena(ena), .i_data(i_data), .i_valid(i_valid),
        .i_ready(l_i_ready), .o_bit(l_o_bit), .o_valid(l_o_valid),
        .o_ready(o_ready), .o_last(l_o_last), .busy(l_busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs already driven: compare,
    // advance the model and the receivers, then move to the next falling edge.
    task automatic step();
        logic exp_m_bit, exp_l_bit, exp_last;
        #1;
        exp_m_bit = mdl_busy ? mdl_word[N-1-mdl_idx] : 1'b0;
        exp_l_bit = mdl_busy ? mdl_word[mdl_idx]     : 1'b1;
        exp_last  = mdl_busy && (mdl_idx == N-1);
        check_eq("m_i_ready", 32'(m_i_ready), 32'(ena & ~mdl_busy));
        check_eq("m_o_valid", 32'(m_o_valid), 32'(mdl_busy));
        check_eq("m_busy",    32'(m_busy_o),  32'(mdl_busy));
        check_eq("m_o_bit",   32'(m_o_bit),   32'(exp_m_bit));
        check_eq("m_o_last",  32'(m_o_last),  32'(exp_last));
        check_eq("l_i_ready", 32'(l_i_ready), 32'(ena & ~mdl_busy));
        check_eq("l_o_valid", 32'(l_o_valid), 32'(mdl_busy));
        check_eq("l_o_bit",   32'(l_o_bit),   32'(exp_l_bit));
        check_eq("l_o_last",  32'(l_o_last),  32'(exp_last));

        if (!rst && ena && o_ready && m_o_valid) begin
            rx_m = {rx_m[N-2:0], m_o_bit};
            if (m_o_last) last_m = rx_m;
        end
        if (!rst && ena && o_ready && l_o_valid) begin
            rx_l = {l_o_bit, rx_l[N-1:1]};
            if (l_o_last) last_l = rx_l;
        end

        if (rst) begin
            mdl_busy = 1'b0;
            mdl_idx  = 0;
        end else if (ena) begin
            if (!mdl_busy && i_valid) begin
                mdl_busy = 1'b1;
                mdl_word = i_data;
                mdl_idx  = 0;
            end else if (mdl_busy && o_ready) begin
                if (mdl_idx == N-1) mdl_busy = 1'b0;
                else mdl_idx++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send one word; steps [stall_at, stall_at+stall_len) after acceptance are
    // stalled by dropping o_ready, or ena when use_ena is set.
    task automatic send(input logic [N-1:0] w, input int stall_at, input int stall_len,
                        input bit use_ena);
        int k;
        rst = 1'b0; ena = 1'b1; o_ready = 1'b1;
        i_data = w; i_valid = 1'b1;
        step();
        k = 0;
        while (mdl_busy && k < 4*N + 16) begin
            i_data  = N'($urandom);
            i_valid = 1'b1;
            if (k >= stall_at && k < stall_at + stall_len) begin
                if (use_ena) ena = 1'b0;
                else         o_ready = 1'b0;
            end else begin
                ena = 1'b1; o_ready = 1'b1;
            end
            step();
            k++;
        end
        check_eq("word_done", 32'(mdl_busy), 32'd0);
        ena = 1'b1; o_ready = 1'b1; i_valid = 1'b0;
        step();
        check_eq("rx_msb", 32'(last_m), 32'(w));
        check_eq("rx_lsb", 32'(last_l), 32'(w));
    endtask

    initial begin
        @(negedge clk);
        // Reset held two cycles, then idle with ena high.
        rst = 1'b1; ena = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        check_eq("idle_i_ready", 32'(m_i_ready), 32'd1);

        send(8'hA5, 100, 0, 1'b0);
        send(8'h01, 100, 0, 1'b0);
        send(8'hC3, 2, 3, 1'b0);
        send(8'h6B, 3, 4, 1'b1);

        // Pulsing i_valid with ena low in idle must not start a word.
        ena = 1'b0; i_valid = 1'b1; i_data = 8'h3C;
        step(); step();
        check_eq("no_accept_ena0", 32'(m_busy_o), 32'd0);
        i_valid = 1'b0; ena = 1'b1;
        step();

        // Abort a word with rst after three bits.
        i_data = 8'hFF; i_valid = 1'b1; o_ready = 1'b1;
        step();
        i_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1; ena = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_eq("abort_idle", 32'(m_o_valid), 32'd0);
        send(8'h81, 100, 0, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(0, 79) == 0);
            ena     = ($urandom_range(0, 7) != 0);
            i_valid = $urandom_range(0, 1) == 1;
            o_ready = ($urandom_range(0, 3) != 0);
            i_data  = N'($urandom);
            step();
        end
        rst = 1'b0; ena = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
        send(8'h5A, 1, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_piso_serializer
`default_nettype wire
